c17_pipe: RTL and testbench



---
 rtl/c17_pipe.sv | 162 ++++++++++++++++
 tb/tb_c17_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_pipe.sv
// ----------------------------------------------------------------------------
// c17_pipe
//   LANES independent copies of the ISCAS c17 benchmark datapath, with up to
//   three optional register stages: S0 on the primary inputs, S1 on the
//   internal nets n8/n10/n12, and S2 on the primary outputs. Stages are joined
//   by a valid/ready handshake. Each stage has a single valid bit and collapses
//   bubbles. A free-running counter records completed output handshakes.
//
// Handshake: a beat moves across a boundary on a posedge where valid and
//   ready are both 1. ready_k = ~valid_k | ready_{k+1}. A stage that is empty,
//   or whose downstream is taking its beat, may load. A loaded bubble leaves
//   the stage's data register unchanged. in_ready never depends on in_valid.
//
// Ports
//   clock            : single clock, all state on posedge
//   reset            : asynchronous, active-high, clears all state
//   in_valid/in_ready: input-side handshake
//   _1,_2,_3,_6,_7   : c17 primary inputs, bit i belongs to lane i
//   out_valid/out_ready : output-side handshake
//   _22,_23          : c17 primary outputs, bit i belongs to lane i
//   xfer_count       : completed output handshakes, modulo 2^CNT_W
// ----------------------------------------------------------------------------
module c17_pipe #(
   parameter int LANES   = 4,
   parameter int IN_REG  = 1,
   parameter int MID_REG = 1,
   parameter int OUT_REG = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] _1,
   input  logic [LANES-1:0] _2,
   input  logic [LANES-1:0] _3,
   input  logic [LANES-1:0] _6,
   input  logic [LANES-1:0] _7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] _22,
   output logic [LANES-1:0] _23,
   output logic [CNT_W-1:0] xfer_count
);

   // Stage-boundary views. Each one comes from a register when the stage is
   // enabled and from its upstream source when it is not.
   logic [5*LANES-1:0] w_s0_in, w_s0_d;
   logic [3*LANES-1:0] w_s1_in, w_s1_d;
   logic [2*LANES-1:0] w_s2_in, w_s2_d;
   logic               w_s0_v, w_s1_v, w_s2_v;
   logic               w_s0_rdy, w_s1_rdy, w_s2_rdy;

   // Per-lane nets. Each is a LANES-wide vector, so bitwise operators keep
   // the lanes independent.
   logic [LANES-1:0] w_a1, w_a2, w_a3, w_a6, w_a7;
   logic [LANES-1:0] w_n9, w_n8, w_n10, w_n12;
   logic [LANES-1:0] w_b8, w_b10, w_b12;
   logic [LANES-1:0] w_o22, w_o23;

   assign w_s0_in = {_7, _6, _3, _2, _1};

   // ---------------- S0 : primary inputs ----------------
   if (IN_REG != 0) begin : g_s0
      logic               r_v;
      logic [5*LANES-1:0] r_d;
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_v <= 1'b0;
            r_d <= '0;
         end else if (w_s0_rdy) begin
            r_v <= in_valid;
            if (in_valid) r_d <= w_s0_in;
         end
      end
      assign w_s0_v   = r_v;
      assign w_s0_d   = r_d;
      assign w_s0_rdy = ~r_v | w_s1_rdy;
   end else begin : g_s0_bypass
      assign w_s0_v   = in_valid;
      assign w_s0_d   = w_s0_in;
      assign w_s0_rdy = w_s1_rdy;
   end

   // First half of c17: n8, n10 and n12 (n9 is only needed locally).
   assign w_a1    = w_s0_d[0*LANES +: LANES];
   assign w_a2    = w_s0_d[1*LANES +: LANES];
   assign w_a3    = w_s0_d[2*LANES +: LANES];
   assign w_a6    = w_s0_d[3*LANES +: LANES];
   assign w_a7    = w_s0_d[4*LANES +: LANES];
   assign w_n9    = w_a3 & w_a6;
   assign w_n8    = w_a1 & w_a3;
   assign w_n10   = w_a2 & ~w_n9;
   assign w_n12   = w_a7 & ~w_n9;
   assign w_s1_in = {w_n12, w_n10, w_n8};

   // ---------------- S1 : internal nets ----------------
   if (MID_REG != 0) begin : g_s1
      logic               r_v;
      logic [3*LANES-1:0] r_d;
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_v <= 1'b0;
            r_d <= '0;
         end else if (w_s1_rdy) begin
            r_v <= w_s0_v;
            if (w_s0_v) r_d <= w_s1_in;
         end
      end
      assign w_s1_v   = r_v;
      assign w_s1_d   = r_d;
      assign w_s1_rdy = ~r_v | w_s2_rdy;
   end else begin : g_s1_bypass
      assign w_s1_v   = w_s0_v;
      assign w_s1_d   = w_s1_in;
      assign w_s1_rdy = w_s2_rdy;
   end

   // Second half of c17: the primary outputs.
   assign w_b8    = w_s1_d[0*LANES +: LANES];
   assign w_b10   = w_s1_d[1*LANES +: LANES];
   assign w_b12   = w_s1_d[2*LANES +: LANES];
   assign w_o22   = w_b8 | w_b10;
   assign w_o23   = w_b10 | w_b12;
   assign w_s2_in = {w_o23, w_o22};

   // ---------------- S2 : primary outputs ----------------
   if (OUT_REG != 0) begin : g_s2
      logic               r_v;
      logic [2*LANES-1:0] r_d;
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_v <= 1'b0;
            r_d <= '0;
         end else if (w_s2_rdy) begin
            r_v <= w_s1_v;
            if (w_s1_v) r_d <= w_s2_in;
         end
      end
      assign w_s2_v   = r_v;
      assign w_s2_d   = r_d;
      assign w_s2_rdy = ~r_v | out_ready;
   end else begin : g_s2_bypass
      assign w_s2_v   = w_s1_v;
      assign w_s2_d   = w_s2_in;
      assign w_s2_rdy = out_ready;
   end

   assign in_ready  = w_s0_rdy;
   assign out_valid = w_s2_v;
   assign _22       = w_s2_d[0*LANES +: LANES];
   assign _23       = w_s2_d[1*LANES +: LANES];

   // Output handshake counter. It wraps naturally at 2^CNT_W.
   logic [CNT_W-1:0] r_xfer_count;
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                       r_xfer_count <= '0;
      else if (out_valid && out_ready) r_xfer_count <= r_xfer_count + 1'b1;
   end
   assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_c17_pipe.sv
// ----------------------------------------------------------------------------
// tb_c17_pipe
//   Four instances share clock, reset and the lane data buses:
//     idx 0 : (1,1,1) CNT_W=16   main instance
//     idx 1 : (1,0,1)            latency check
//     idx 2 : (0,0,0)            purely combinational latency check
//     idx 3 : (1,1,1) CNT_W=3    counter wrap
//   The reference model is the original c17 NAND netlist, evaluated lane by
//   lane.
// ----------------------------------------------------------------------------
module tb_c17_pipe;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   // ---------------- DUT connections ----------------
   logic [3:0]       in1, in2, in3, in6, in7;
   logic [3:0]       iv, ordy, ir, ov;
   logic [3:0][3:0]  o22, o23;
   logic [15:0]      xc_a, xc_b, xc_c;
   logic [2:0]       xc_w;

   c17_pipe #(.LANES(4), .IN_REG(1), .MID_REG(1), .OUT_REG(1), .CNT_W(16)) u_a (
      .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
      ._1(in1), ._2(in2), ._3(in3), ._6(in6), ._7(in7),
      .out_valid(ov[0]), .out_ready(ordy[0]), ._22(o22[0]), ._23(o23[0]),
      .xfer_count(xc_a));

   c17_pipe #(.LANES(4), .IN_REG(1), .MID_REG(0), .OUT_REG(1), .CNT_W(16)) u_b (
      .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
      ._1(in1), ._2(in2), ._3(in3), ._6(in6), ._7(in7),
      .out_valid(ov[1]), .out_ready(ordy[1]), ._22(o22[1]), ._23(o23[1]),
      .xfer_count(xc_b));

   c17_pipe #(.LANES(4), .IN_REG(0), .MID_REG(0), .OUT_REG(0), .CNT_W(16)) u_c (
      .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
      ._1(in1), ._2(in2), ._3(in3), ._6(in6), ._7(in7),
      .out_valid(ov[2]), .out_ready(ordy[2]), ._22(o22[2]), ._23(o23[2]),
      .xfer_count(xc_c));

   c17_pipe #(.LANES(4), .IN_REG(1), .MID_REG(1), .OUT_REG(1), .CNT_W(3)) u_w (
      .clock(clock), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]),
      ._1(in1), ._2(in2), ._3(in3), ._6(in6), ._7(in7),
      .out_valid(ov[3]), .out_ready(ordy[3]), ._22(o22[3]), ._23(o23[3]),
      .xfer_count(xc_w));

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: the c17 NAND netlist. Data packing is {in7,in6,in3,in2,in1}.
   // The result is {_23,_22}.
   function automatic logic [7:0] c17_model(input logic [19:0] d);
      logic [7:0] r;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         logic x1, x2, x3, x6, x7, g10, g11, g16, g19;
         x1 = d[l]; x2 = d[4+l]; x3 = d[8+l]; x6 = d[12+l]; x7 = d[16+l];
         g10 = ~(x1 & x3);
         g11 = ~(x3 & x6);
         g16 = ~(x2 & g11);
         g19 = ~(g11 & x7);
         r[l]   = ~(g10 & g16);
         r[4+l] = ~(g16 & g19);
      end
      return r;
   endfunction

   // ---------------- driver ----------------
   // Called at a negedge. Drives one cycle on instance d and samples the
   // handshake 4 time units later. It records accepted beats and checks
   // delivered ones, then returns at the following negedge.
   task automatic cycle(input int d, input logic v, input logic [19:0] data, input logic rdy,
                        output logic acc, output logic dlv, output logic [7:0] obs);
      logic [7:0] e;
      iv[d]   = v;
      ordy[d] = rdy;
      {in7, in6, in3, in2, in1} = data;
      #4;
      acc = iv[d] & ir[d];
      dlv = ov[d] & ordy[d];
      obs = {o23[d], o22[d]};
      if (acc) exp_q.push_back(c17_model(data));
      if (dlv) begin
         check("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", obs, e);
         end
      end
      @(posedge clock);
      @(negedge clock);
      iv[d] = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Sends one beat on cycle 0, idles with out_ready=1, and measures when
   // out_valid appears and for how many cycles it stays up.
   task automatic latency_test(input int d, input logic [19:0] data, input int exp_lat,
                               output logic [7:0] got);
      logic acc, dlv;
      logic [7:0] obs;
      int lat, cnt;
      lat = -1; cnt = 0; got = '0;
      cycle(d, 1'b1, data, 1'b1, acc, dlv, obs);
      check("lat_accept", acc, 1);
      if (dlv) begin cnt++; lat = 0; got = obs; end
      for (int c = 1; c < 8; c++) begin
         cycle(d, 1'b0, 20'($urandom), 1'b1, acc, dlv, obs);
         if (dlv) begin
            cnt++;
            if (lat < 0) begin lat = c; got = obs; end
         end
      end
      check("latency", lat, exp_lat);
      check("valid_cycles", cnt, 1);
   endtask

   // ---------------- main sequence ----------------
   localparam logic [19:0] TT_DATA = {4'b0101, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

   initial begin
      logic acc, dlv;
      logic [7:0] obs, got;
      logic [19:0] data;
      int acc_n, dlv_n, cyc, k, sent;

      reset = 1'b1;
      iv = '0; ordy = '1;
      {in7, in6, in3, in2, in1} = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      ordy[0] = 1'b0;
      #1;
      check("rst_out_valid", ov[0], 0);
      check("rst_in_ready", ir[0], 1);
      check("rst_xfer", xc_a, 0);
      check("rst_out22", o22[0], 0);
      check("rst_out23", o23[0], 0);
      ordy[0] = 1'b1;
      @(negedge clock);

      // Truth table and latency, default configuration
      latency_test(0, TT_DATA, 3, got);
      check("tt_outputs", got, 8'h63);

      // Latency, (1,0,1) and (0,0,0)
      do_reset();
      data = 20'($urandom);
      latency_test(1, data, 2, got);
      check("lat_b_value", got, c17_model(data));
      check("lat_b_xfer", xc_b, 1);
      do_reset();
      data = 20'($urandom);
      latency_test(2, data, 0, got);
      check("lat_c_value", got, c17_model(data));
      check("lat_c_xfer", xc_c, 1);

      // Sweep all 32 patterns on every lane; lanes see staggered patterns
      do_reset();
      dlv_n = 0;
      for (int p = 0; p < 32; p++) begin
         for (int l = 0; l < 4; l++) begin
            logic [4:0] pat;
            pat = 5'((p + 7 * l) % 32);
            for (int b = 0; b < 5; b++) data[4*b + l] = pat[b];
         end
         cycle(0, 1'b1, data, 1'b1, acc, dlv, obs);
         dlv_n += int'(dlv);
      end
      for (int c = 0; c < 6; c++) begin
         cycle(0, 1'b0, '0, 1'b1, acc, dlv, obs);
         dlv_n += int'(dlv);
      end
      check("sweep_delivered", dlv_n, 32);
      check("sweep_sb_empty", exp_q.size(), 0);

      // Backpressure: out_ready low from reset
      do_reset();
      for (int c = 0; c < 5; c++) begin
         cycle(0, 1'b1, 20'($urandom), 1'b0, acc, dlv, obs);
         check("bp_in_ready", acc, (c < 3) ? 1 : 0);
         check("bp_no_out", dlv, 0);
      end
      for (int c = 0; c < 6; c++) begin
         cycle(0, 1'b1, 20'($urandom), 1'b1, acc, dlv, obs);
         check("bp_drain_acc", acc, 1);
         check("bp_drain_dlv", dlv, 1);
      end
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 10) begin
         cycle(0, 1'b0, '0, 1'b1, acc, dlv, obs);
         cyc++;
      end
      check("bp_sb_empty", exp_q.size(), 0);

      // Random stall
      do_reset();
      acc_n = 0; dlv_n = 0; cyc = 0;
      while ((acc_n < 1000 || exp_q.size() != 0) && cyc < 20000) begin
         cycle(0, (acc_n < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, 20'($urandom),
               1'($urandom_range(0, 1)), acc, dlv, obs);
         acc_n += int'(acc);
         dlv_n += int'(dlv);
         cyc++;
      end
      check("rand_accepted", acc_n, 1000);
      check("rand_delivered", dlv_n, 1000);
      check("rand_xfer", xc_a, 1000);

      // Reset mid-operation
      do_reset();
      cycle(0, 1'b1, 20'($urandom), 1'b1, acc, dlv, obs);
      cycle(0, 1'b1, 20'($urandom), 1'b1, acc, dlv, obs);
      cycle(0, 1'b0, '0, 1'b1, acc, dlv, obs);
      cycle(0, 1'b0, '0, 1'b1, acc, dlv, obs);
      cycle(0, 1'b1, 20'($urandom), 1'b0, acc, dlv, obs);
      check("mid_pre_xfer", xc_a, 1);
      check("mid_pre_valid", ov[0], 1);
      ordy[0] = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_out_valid", ov[0], 0);
      check("mid_xfer", xc_a, 0);
      check("mid_in_ready", ir[0], 1);
      check("mid_out22", o22[0], 0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      data = 20'($urandom);
      latency_test(0, data, 3, got);
      check("mid_post_value", got, c17_model(data));

      // Counter wrap, CNT_W = 3
      do_reset();
      k = 0; sent = 0; cyc = 0;
      while (k < 9 && cyc < 40) begin
         cycle(3, sent < 9, 20'($urandom), 1'b1, acc, dlv, obs);
         sent += int'(acc);
         if (dlv) begin
            k++;
            check("wrap_count", xc_w, k % 8);
         end
         cyc++;
      end
      check("wrap_total", k, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
